seg7_scan_ctrl: RTL and testbench

//  Time-multiplexes one hexto7segment decoder across NUM_DIGITS common-anode digits.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/hexto7segment.sv | 33 +++
 rtl/seg7_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the multiplexed seven-segment scanner.
//   SEG_BLANK          : segment pattern with every segment off (active-low bus)
//   DISP_BLANK_NIBBLE  : display nibble that the decoder renders as blank
//   scan_state_t       : per-slot scan phase (BLANK interval, then DRIVE)
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK         = 7'b1111111;
  localparam logic [3:0] DISP_BLANK_NIBBLE = 4'hF;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hexto7segment.sv
// -----------------------------------------------------------------------------
// hexto7segment
// Combinational decoder from a 4-bit digit value to an active-low abcdefg
// segment pattern (a = MSB). Only 0..9 light segments; A..F decode blank.
// Ports:
//   x : digit value to decode
//   r : segment pattern, active-low
// -----------------------------------------------------------------------------
module hexto7segment
  import seg7_pkg::*;
(
  input  logic [3:0] x,
  output logic [6:0] r
);

  always_comb begin
    r = SEG_BLANK;
    case (x)
      4'h0: r = 7'b0000001;
      4'h1: r = 7'b1001111;
      4'h2: r = 7'b0010010;
      4'h3: r = 7'b0000110;
      4'h4: r = 7'b1001100;
      4'h5: r = 7'b0100100;
      4'h6: r = 7'b0100000;
      4'h7: r = 7'b0001111;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0000100;
      default: r = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexes one hexto7segment decoder across NUM_DIGITS common-anode
// digits. Each digit slot lasts REFRESH_DIV cycles and begins with
// BLANK_CYCLES cycles of all anodes off to avoid ghosting.
// Ports:
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   wr_valid    : wr_data carries a new display value
//   wr_ready    : shadow register is free
//   wr_data     : new display value, nibble k drives digit k
//   digit_en    : live per-digit enable, 0 keeps that anode off
//   an          : anode select, active-low one-hot (all ones = dark)
//   seg         : segments abcdefg, active-low, registered
//   frame_start : one-cycle pulse as the digit 0 slot begins
//
// Write handshake: a value transfers on any rising edge where wr_valid and
// wr_ready are both 1. wr_ready is exactly ~pending, so once a value sits in
// the shadow register further wr_valid is ignored until that value has been
// committed to the display at the next frame boundary (no tearing).
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]           slot_cnt;
  logic [CNT_W-1:0]           slot_cnt_next;
  logic [IDX_W-1:0]           digit_idx;
  scan_state_t                state;
  scan_state_t                state_next;
  logic [NUM_DIGITS-1:0][3:0] disp;
  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic                       pending;
  logic                       pending_next;
  logic                       slot_wrap;
  logic                       frame_bnd;
  logic                       accept;
  logic [3:0]                 dec_in;
  logic [6:0]                 dec_out;
  logic [NUM_DIGITS-1:0]      an_drive;

  assign slot_wrap = (slot_cnt == CNT_LAST);
  assign frame_bnd = slot_wrap && (digit_idx == IDX_LAST);
  assign accept    = wr_valid && wr_ready;

  // The state register tracks the phase of the counter value it is loaded
  // alongside, so state always describes the current slot_cnt.
  always_comb begin
    slot_cnt_next = slot_wrap ? '0 : slot_cnt + 1'b1;
    state_next    = (slot_cnt_next < CNT_BLANK) ? BLANK : DRIVE;
  end

  // Commit and accept are mutually exclusive: commit needs pending=1, which
  // holds wr_ready low.
  always_comb begin
    pending_next = pending;
    if (frame_bnd && pending) begin
      pending_next = 1'b0;
    end else if (accept) begin
      pending_next = 1'b1;
    end
  end

  // Only the selected digit's anode can go low, and only if it is enabled.
  always_comb begin
    an_drive = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        an_drive[k] = ~digit_en[k];
      end
    end
  end

  assign dec_in = disp[digit_idx];

  hexto7segment u_dec (
    .x (dec_in),
    .r (dec_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      state       <= BLANK;
      pending     <= 1'b0;
      shadow      <= {NUM_DIGITS{DISP_BLANK_NIBBLE}};
      disp        <= {NUM_DIGITS{DISP_BLANK_NIBBLE}};
      wr_ready    <= 1'b0;
      an          <= '1;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt_next;
      if (slot_wrap) begin
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end
      state       <= state_next;
      pending     <= pending_next;
      wr_ready    <= ~pending_next;
      if (accept) begin
        shadow <= wr_data;
      end
      if (frame_bnd && pending) begin
        disp <= shadow;
      end
      frame_start <= frame_bnd;
      if (state == DRIVE) begin
        an  <= an_drive;
        seg <= dec_out;
      end else begin
        an  <= '1;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. The bench keeps its own count t of clock edges since reset
// release; the scan state at edge count p is slot p%8 of digit (p/8)%4, and
// the registered an/seg seen at t reflect scan position t-1. Expected segment
// patterns are queued when a display value is written and popped as each
// digit slot of the following frame is observed.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int pulses;

  logic [6:0] exp_q[$];

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .digit_en    (digit_en),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed %h expected %h", tag, t, got, exp);
    end
  endtask

  // One clock: inputs change on the falling edge, outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    if (rst) t = 0;
    else     t++;
    @(negedge clk);
  endtask

  function automatic bit at_pos(input int idx, input int cnt);
    return (t >= 1) && (((t - 1) % RD) == cnt) && ((((t - 1) / RD) % ND) == idx);
  endfunction

  task automatic wait_pos(input int idx, input int cnt);
    int n = 0;
    while (!at_pos(idx, cnt) && n < 80) begin
      tick();
      n++;
    end
    checks++;
    assert (at_pos(idx, cnt)) else begin
      errors++;
      $error("FAIL wait_pos t=%0d observed idx/cnt not reached expected %0d/%0d", t, idx, cnt);
    end
  endtask

  task automatic wait_t(input int target);
    int n = 0;
    while (t < target && n < 200) begin
      tick();
      n++;
    end
    check("wait_t", 16'(t), 16'(target));
  endtask

  function automatic logic [6:0] pop_exp();
    if (exp_q.size() == 0) return 7'bx;
    return exp_q.pop_front();
  endfunction

  // Whole slot of one digit: 2 dark cycles, then 6 driven cycles.
  task automatic check_slot(input int idx, input logic [3:0] an_exp, input logic [6:0] seg_exp);
    wait_pos(idx, 0);
    for (int c = 0; c < RD; c++) begin
      if (c > 0) tick();
      if (c < BC) begin
        check($sformatf("blank_an_d%0d_c%0d", idx, c), 16'(an), 16'hF);
        check($sformatf("blank_seg_d%0d_c%0d", idx, c), 16'(seg), 16'h7F);
      end else begin
        check($sformatf("drive_an_d%0d_c%0d", idx, c), 16'(an), 16'(an_exp));
        check($sformatf("drive_seg_d%0d_c%0d", idx, c), 16'(seg), 16'(seg_exp));
      end
    end
  endtask

  task automatic do_write(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    // reset
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    digit_en = 4'b1111;
    repeat (3) tick();
    check("rst_an", 16'(an), 16'hF);
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_ready", 16'(wr_ready), 16'h0);
    check("rst_fs", 16'(frame_start), 16'h0);
    rst = 1'b0;
    tick();
    check("rel_ready", 16'(wr_ready), 16'h1);
    check("rel_an", 16'(an), 16'hF);
    check_slot(0, 4'b1110, 7'h7F);

    // write 4321 mid-frame
    do_write(16'h4321);
    check("acc_ready", 16'(wr_ready), 16'h0);
    exp_q.push_back(7'b1001111);
    exp_q.push_back(7'b0010010);
    exp_q.push_back(7'b0000110);
    exp_q.push_back(7'b1001100);
    wait_pos(3, 5);
    check("pre_an", 16'(an), 16'b0111);
    check("pre_seg", 16'(seg), 16'h7F);
    wait_t(31);
    check("pre_bnd_ready", 16'(wr_ready), 16'h0);
    check("pre_bnd_fs", 16'(frame_start), 16'h0);
    tick();
    check("bnd_fs", 16'(frame_start), 16'h1);
    check("bnd_ready", 16'(wr_ready), 16'h1);
    tick();
    check("post_fs", 16'(frame_start), 16'h0);
    check_slot(0, 4'b1110, pop_exp());
    check_slot(1, 4'b1101, pop_exp());
    check_slot(2, 4'b1011, pop_exp());
    check_slot(3, 4'b0111, pop_exp());

    // 0009 accepted, 8888 offered while busy must be dropped
    do_write(16'h0009);
    check("acc2_ready", 16'(wr_ready), 16'h0);
    wr_valid = 1'b1;
    wr_data  = 16'h8888;
    repeat (5) begin
      tick();
      check("busy_ready", 16'(wr_ready), 16'h0);
    end
    wr_valid = 1'b0;
    exp_q.push_back(7'b0000100);
    exp_q.push_back(7'b0000001);
    exp_q.push_back(7'b0000001);
    exp_q.push_back(7'b0000001);
    wait_t(96);
    check("bnd2_fs", 16'(frame_start), 16'h1);
    check("bnd2_ready", 16'(wr_ready), 16'h1);
    check_slot(0, 4'b1110, pop_exp());
    check_slot(1, 4'b1101, pop_exp());
    check_slot(2, 4'b1011, pop_exp());
    check_slot(3, 4'b0111, pop_exp());

    // A765 with digit 2 disabled
    do_write(16'hA765);
    digit_en = 4'b1011;
    exp_q.push_back(7'b0100100);
    exp_q.push_back(7'b0100000);
    exp_q.push_back(7'b0001111);
    exp_q.push_back(7'b1111111);
    wait_t(160);
    check("bnd3_fs", 16'(frame_start), 16'h1);
    check_slot(0, 4'b1110, pop_exp());
    check_slot(1, 4'b1101, pop_exp());
    check_slot(2, 4'b1111, pop_exp());
    check_slot(3, 4'b0111, pop_exp());

    // frame_start period over two frames, then wrap 3 -> 0
    pulses = 0;
    repeat (2 * FRAME) begin
      tick();
      check("fs_period", 16'(frame_start), 16'((t % FRAME) == 0));
      if (frame_start === 1'b1) pulses++;
    end
    check("fs_pulses", 16'(pulses), 16'd2);
    check_slot(0, 4'b1110, 7'b0100100);

    // reset during digit 2 DRIVE with a write pending
    digit_en = 4'b1111;
    do_write(16'h1111);
    wait_pos(2, 4);
    check("mid_an", 16'(an), 16'b1011);
    check("mid_seg", 16'(seg), 16'(7'b0001111));
    check("mid_ready", 16'(wr_ready), 16'h0);
    rst = 1'b1;
    tick();
    check("rst2_an", 16'(an), 16'hF);
    check("rst2_seg", 16'(seg), 16'h7F);
    check("rst2_ready", 16'(wr_ready), 16'h0);
    check("rst2_fs", 16'(frame_start), 16'h0);
    rst = 1'b0;
    tick();
    check("rel2_ready", 16'(wr_ready), 16'h1);
    check_slot(0, 4'b1110, 7'h7F);
    wait_t(32);
    check("bnd4_fs", 16'(frame_start), 16'h1);
    check("bnd4_ready", 16'(wr_ready), 16'h1);
    check_slot(0, 4'b1110, 7'h7F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
